// File: rtl/regfile_read_arbiter_if.sv
// Register-file read port bundle shared by the requesters and the arbiter.
//
// Handshake: Req[i] is a level request that the requester holds with a stable
// ReqAddr slice until it sees Gnt[i] (combinational, same cycle); the read is
// performed in that cycle and the data comes back exactly one cycle later as a
// single-cycle RespValid[i] pulse with RespData. There is no back-pressure on
// the response side, and Stall suppresses all grants.
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int PTR_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        Req;
  logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
  logic                      Stall;
  logic [ADDR_W-1:0]         ReadRegister;
  logic [DATA_W-1:0]         ReadData;
  logic [NUM_REQ-1:0]        Gnt;
  logic [NUM_REQ-1:0]        RespValid;
  logic [DATA_W-1:0]         RespData;
  // Round-robin pointer, exported for observation only.
  logic [PTR_W-1:0]          DbgPtr;

  // Requester/mux side: drives requests and the mux read data.
  modport master (
    output Req, ReqAddr, Stall, ReadData,
    input  ReadRegister, Gnt, RespValid, RespData, DbgPtr
  );

  // Arbiter side.
  modport slave (
    input  Req, ReqAddr, Stall, ReadData,
    output ReadRegister, Gnt, RespValid, RespData, DbgPtr
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing the single register-file read mux among
// NUM_REQ requesters. The winner's address drives the mux select in the
// grant cycle; the mux output is registered and returned one cycle later.
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_read_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_idx, scan_idx;
  logic               win_found;
  logic [ADDR_W-1:0]  last_sel_q;
  logic [ADDR_W-1:0]  win_addr;
  logic [ADDR_W-1:0]  lane_addr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt_d;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [DATA_W-1:0]  resp_data_q;

  // Unpack the flat address bus into one entry per lane.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_addr[i] = bus.ReqAddr[i*ADDR_W +: ADDR_W];
    end
  end

  // Rotating-priority search: first requester at or after the pointer wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((32'(ptr_q) + 32'(k)) % 32'(NUM_REQ));
      if (!win_found && bus.Req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
    // Stall suppresses the grant entirely; the pointer then holds as well.
    if (bus.Stall) begin
      win_found = 1'b0;
    end
  end

  // One-hot grant, winner address and the pointer advance past the winner.
  always_comb begin
    gnt_d    = '0;
    win_addr = lane_addr[win_idx];
    ptr_d    = ptr_q;
    if (win_found) begin
      gnt_d[win_idx] = 1'b1;
      ptr_d          = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end
  end

  // Select is held at the last granted address while idle so the mux stays quiet.
  assign bus.ReadRegister = win_found ? win_addr : last_sel_q;
  assign bus.Gnt          = gnt_d;
  assign bus.RespValid    = resp_valid_q;
  assign bus.RespData     = resp_data_q;
  assign bus.DbgPtr       = ptr_q;

  // Capture the mux output for the winner; a cycle without a grant only drops valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      last_sel_q   <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else if (win_found) begin
      ptr_q        <= ptr_d;
      last_sel_q   <= win_addr;
      resp_valid_q <= gnt_d;
      resp_data_q  <= bus.ReadData;
    end else begin
      resp_valid_q <= '0;
    end
  end
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed scenarios plus random traffic,
// reference model of the round-robin rule, and a scoreboard of timed responses.
module tb_regfile_read_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int PTR_W   = 2;
  localparam int AW_ALL  = NUM_REQ * ADDR_W;
  // Scoreboard entry: {due cycle, expected RespValid, expected RespData}.
  localparam int EW      = 16 + NUM_REQ + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  regfile_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register file contents behind the read mux.
  logic [DATA_W-1:0] regs [32];
  assign bus.ReadData = regs[bus.ReadRegister];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  // Reference model state.
  int          m_ptr  = 0;
  logic [ADDR_W-1:0] m_last = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW_ALL-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  // ---------------- monitor ----------------
  // Every cycle outside reset, a response is due exactly when the head entry
  // is scheduled for this cycle; otherwise the response lanes must be quiet.
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0][EW-1 -: 16] == cyc) begin
        mon_e = exp_q.pop_front();
        check("resp_valid", 64'(bus.RespValid), 64'(mon_e[DATA_W +: NUM_REQ]));
        check("resp_data",  64'(bus.RespData),  64'(mon_e[DATA_W-1:0]));
      end else begin
        check("resp_idle", 64'(bus.RespValid), 64'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // Applies one cycle of inputs, checks the combinational grant against the
  // round-robin rule, schedules the response and advances the model.
  task automatic drive(input logic [NUM_REQ-1:0] req, input logic [AW_ALL-1:0] addrs,
                       input logic stall);
    int w;
    int j;
    logic [ADDR_W-1:0]  a;
    logic [NUM_REQ-1:0] eg;
    bus.Req     = req;
    bus.ReqAddr = addrs;
    bus.Stall   = stall;
    #2;
    w = -1;
    if (!stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (m_ptr + k) % NUM_REQ;
        if (w < 0 && req[j]) w = j;
      end
    end
    eg = '0;
    a  = m_last;
    if (w >= 0) begin
      eg[w] = 1'b1;
      a     = addrs[w*ADDR_W +: ADDR_W];
    end
    check("gnt",      64'(bus.Gnt),          64'(eg));
    check("read_reg", 64'(bus.ReadRegister), 64'(a));
    check("ptr",      64'(bus.DbgPtr),       64'(m_ptr));
    if (w >= 0) begin
      exp_q.push_back({cyc + 16'd1, eg, regs[a]});
      m_ptr  = (w + 1) % NUM_REQ;
      m_last = a;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NUM_REQ-1:0] rreq;
    logic [AW_ALL-1:0]  raddr;
    logic               rstall;

    reset       = 1'b1;
    bus.Req     = '0;
    bus.ReqAddr = '0;
    bus.Stall   = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[5]  = 32'hDEADBEEF;
    regs[17] = 32'h1717_A5A5;

    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 64'(bus.RespValid),    64'd0);
    check("rst_resp_data",  64'(bus.RespData),     64'd0);
    check("rst_gnt",        64'(bus.Gnt),          64'd0);
    check("rst_read_reg",   64'(bus.ReadRegister), 64'd0);
    check("rst_ptr",        64'(bus.DbgPtr),       64'd0);
    reset = 1'b0;

    // Single request from lane 1 at address 5; pointer lands on 2.
    drive(4'b0010, pack4(0, 5, 0, 0), 1'b0);
    drive(4'b0000, pack4(0, 0, 0, 0), 1'b0);

    // All lanes continuously requesting: strict rotation, one grant per cycle.
    repeat (12) drive(4'b1111, pack4(1, 2, 3, 4), 1'b0);

    // Walk the pointer to 3, then lanes 0 and 3 compete across the wrap.
    drive(4'b0100, pack4(0, 0, 9, 0), 1'b0);
    drive(4'b1001, pack4(6, 0, 0, 7), 1'b0);
    drive(4'b1001, pack4(6, 0, 0, 7), 1'b0);

    // Stall for three cycles holds everything, then lane 2 is granted at once.
    repeat (3) drive(4'b0100, pack4(0, 0, 12, 0), 1'b1);
    drive(4'b0100, pack4(0, 0, 12, 0), 1'b0);

    // Read of address 17, then idle: select stays at 17.
    drive(4'b0010, pack4(0, 17, 0, 0), 1'b0);
    repeat (4) drive(4'b0000, pack4(3, 8, 11, 30), 1'b0);

    // Reset in the cycle a lane-0 response is presented: cleared without a clock.
    drive(4'b0001, pack4(21, 0, 0, 0), 1'b0);
    bus.Req = '0;
    reset   = 1'b1;
    #1;
    check("midrst_resp_valid", 64'(bus.RespValid), 64'd0);
    check("midrst_resp_data",  64'(bus.RespData),  64'd0);
    check("midrst_ptr",        64'(bus.DbgPtr),    64'd0);
    exp_q.delete();
    m_ptr  = 0;
    m_last = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(4'b0000, pack4(0, 0, 0, 0), 1'b0);

    // Random traffic with occasional stalls.
    for (int n = 0; n < 400; n++) begin
      rreq   = 4'($urandom);
      raddr  = 20'($urandom);
      rstall = ($urandom_range(0, 7) == 0);
      drive(rreq, raddr, rstall);
    end

    repeat (3) drive(4'b0000, pack4(0, 0, 0, 0), 1'b0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Round-robin arbiter that shares the single 32-bit register-file read port (the 32x32-to-32 read multiplexer) among up to NUM_REQ requesters, for example the decode-stage rs/rt reads and a debug/scan reader. Each cycle it selects at most one pending requester and drives that requester's address onto the mux select. It captures the mux output into a registered response and returns the data to the winner one cycle later. It sits between the requesting pipeline stages and the register-file read mux.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 5, register address width (mux select width)
- DATA_W, 32, register data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- Req  in  NUM_REQ  per-requester read request; level, held until granted
- ReqAddr  in  NUM_REQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
- Stall  in  1  when high, no grant issued and pointer frozen
- ReadRegister  out  ADDR_W  select driven to the read mux
- ReadData  in  DATA_W  combinational data returned by the read mux
- Gnt  out  NUM_REQ  one-hot grant, combinational in the cycle the read is performed
- RespValid  out  NUM_REQ  one-hot, registered; high for exactly one cycle per grant
- RespData  out  DATA_W  registered read data, valid when any RespValid bit is high

## Operation
- State: round-robin pointer Ptr (0..NUM_REQ-1), last-select register LastSel (ADDR_W), response registers RespValid/RespData.
- Arbitration, each cycle: if Stall=0 and Req!=0, winner W = first i with Req[i]=1, searching Ptr, Ptr+1, ..., NUM_REQ-1, 0, ..., Ptr-1 (modulo NUM_REQ).
- Gnt = onehot(W) when a winner exists, else 0. Gnt never has more than one bit set.
- ReadRegister = ReqAddr slice W when a winner exists, else LastSel (select held stable while idle).
- On the clock edge after a grant: LastSel <= ReqAddr[W], RespData <= ReadData, RespValid <= onehot(W), Ptr <= (W+1) mod NUM_REQ.
- On an edge with no grant: RespValid <= 0; RespData, LastSel and Ptr hold.
- Requester i deasserts Req[i] (or presents a new address) in the cycle after Gnt[i]. A Req held high after a grant is treated as a new request.
- Address 0 is not special-cased; the read mux returns whatever is presented for register 0.
- Stall=1 forces Gnt=0 and RespValid<=0 on the next edge. It does not cancel a RespValid already registered for the current cycle.
- ReqAddr of non-requesting lanes is ignored.

## Timing
- Reset values (asynchronous, immediate): Ptr=0, LastSel=0, ReadRegister=0 when no request is pending, Gnt=0 while Req=0, RespValid=0, RespData=0.
- Reset asserted mid-operation: pending RespValid is cleared immediately and the response is lost. Requesters must re-request after reset deasserts.
- Latency: Req[i] high in cycle T with no contention -> Gnt[i] high in T -> RespValid[i]=1 and RespData=reg[ReqAddr_i] in cycle T+1.
- Throughput: one read per cycle, back-to-back grants allowed.
- Fairness: with all NUM_REQ lanes continuously requesting, each lane is granted exactly once every NUM_REQ cycles. Maximum wait is NUM_REQ-1 cycles, excluding Stall cycles.
- Gnt and ReadRegister are combinational from Req/ReqAddr/Ptr/Stall. The ReadData path is a single combinational hop: arbiter -> mux -> RespData register.
- Ptr wrap: W = NUM_REQ-1 sets Ptr to 0.

## Test plan
- Reset, then single request: Req=4'b0010, lane1 addr=5 with reg5=0xDEADBEEF -> Gnt=4'b0010 in the same cycle, next cycle RespValid=4'b0010, RespData=0xDEADBEEF, Ptr=2.
- All four lanes request continuously with addrs 1,2,3,4 -> grant order 0,1,2,3,0,... One grant per cycle, and RespData each cycle equals reg[addr] of the previous grant.
- Ptr=3 with Req=4'b1001 -> lane3 granted, Ptr wraps to 0; next cycle lane0 granted.
- Stall=1 for 3 cycles with Req=4'b0100 -> Gnt=0 and RespValid=0 throughout, Ptr unchanged, ReadRegister=LastSel. Stall drop -> lane2 granted in the same cycle.
- Assert reset in the cycle RespValid=4'b0001 -> RespValid, RespData and Ptr go to 0 immediately without waiting for clk. After release with Req=0: Gnt=0, ReadRegister=0.
- Idle after a read of addr 17 -> ReadRegister stays 17 and RespValid=0 until the next Req.
